// File: rtl/xge_tx_arb_pkg.sv
// Shared types and constants for the XGE TX packet arbiter and its round-robin picker.
package xge_tx_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int MOD_W   = 3;
    localparam int DATA_W  = 64;

    typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

endpackage

// File: rtl/xge_rr_picker.sv
// Combinational round-robin picker: returns the first eligible index after pointer_i, wrapping.
module xge_rr_picker
    import xge_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GNT_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [GNT_W-1:0] pointer_i,
    output logic             valid_o,
    output logic [GNT_W-1:0] index_o
);

    logic [GNT_W-1:0] cand;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        valid_o = 1'b0;
        index_o = '0;
        cand    = '0;
        // Walk from farthest to nearest so the closest eligible index after the pointer wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= N_REQ) begin
                cand = GNT_W'((int'(pointer_i) + k) % N_REQ);
                if (eligible_i[cand]) begin
                    valid_o = 1'b1;
                    index_o = cand;
                end
            end
        end
    end

endmodule

// File: rtl/xge_tx_pkt_arbiter.sv
// Packet-boundary round-robin arbiter in front of the xge_mac TX FIFO.
// Define XGE_TX_ARB_PRIO_EN to give requester 0 strict priority at each arbitration.
module xge_tx_pkt_arbiter
    import xge_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GNT_W = $clog2(N_REQ)
) (
    input  logic                    clk_156m25,
    input  logic                    reset_156m25_n,
    input  logic [N_REQ-1:0]        req_val,
    input  logic [N_REQ-1:0]        req_sop,
    input  logic [N_REQ-1:0]        req_eop,
    input  logic [MOD_W*N_REQ-1:0]  req_mod,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_rdy,
    input  logic                    pkt_tx_full,
    output logic                    pkt_tx_val,
    output logic                    pkt_tx_sop,
    output logic                    pkt_tx_eop,
    output logic [MOD_W-1:0]        pkt_tx_mod,
    output logic [DATA_W-1:0]       pkt_tx_data,
    output logic [GNT_W-1:0]        gnt_id,
    output logic                    busy,
    output logic                    proto_err,
    output logic [31:0]             pkt_cnt
);

    arb_state_t        state_q, state_d;
    logic [GNT_W-1:0]  gnt_q, gnt_d;
    logic [GNT_W-1:0]  ptr_q, ptr_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              val_q, sop_q, eop_q;
    logic [MOD_W-1:0]  mod_q;
    logic [DATA_W-1:0] data_q;

    logic [N_REQ-1:0]  eligible;
    logic              pick_valid;
    logic [GNT_W-1:0]  pick_idx;
    logic              accept;
    logic              sel_val, sel_sop, sel_eop;
    logic [MOD_W-1:0]  sel_mod;
    logic [DATA_W-1:0] sel_data;

    assign eligible = req_val & req_sop;

`ifdef XGE_TX_ARB_PRIO_EN
    logic             rr_valid;
    logic [GNT_W-1:0] rr_idx;

    // Requester 0 is taken out of the rotation and wins outright whenever it is eligible.
    xge_rr_picker #(.N_REQ(N_REQ), .GNT_W(GNT_W)) u_rr_picker (
        .eligible_i ({eligible[N_REQ-1:1], 1'b0}),
        .pointer_i  (ptr_q),
        .valid_o    (rr_valid),
        .index_o    (rr_idx)
    );

    assign pick_valid = eligible[0] | rr_valid;
    assign pick_idx   = eligible[0] ? '0 : rr_idx;
`else
    xge_rr_picker #(.N_REQ(N_REQ), .GNT_W(GNT_W)) u_rr_picker (
        .eligible_i (eligible),
        .pointer_i  (ptr_q),
        .valid_o    (pick_valid),
        .index_o    (pick_idx)
    );
`endif

    always_comb begin
        sel_val  = 1'b0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_mod  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q == GNT_W'(i)) begin
                sel_val  = req_val[i];
                sel_sop  = req_sop[i];
                sel_eop  = req_eop[i];
                sel_mod  = req_mod[MOD_W*i +: MOD_W];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        req_rdy = '0;
        accept  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    first_d = 1'b1;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                req_rdy[gnt_q] = !pkt_tx_full;
                accept         = sel_val & !pkt_tx_full;
                if (accept) begin
                    first_d = 1'b0;
                    // A second sop inside a packet is flagged but the word still goes out.
                    if (sel_sop && !first_q) begin
                        err_d = 1'b1;
                    end
                    if (sel_eop) begin
                        cnt_d   = cnt_q + 32'd1;
                        ptr_d   = gnt_q;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
        if (!reset_156m25_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        // NOTE: the output word registers are reset as well, since every output must read 0 in reset.
        if (!reset_156m25_n) begin
            gnt_q   <= '0;
            ptr_q   <= GNT_W'(N_REQ - 1);
            first_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            mod_q   <= '0;
            data_q  <= '0;
        end else begin
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            val_q   <= accept;
            if (accept) begin
                sop_q  <= sel_sop;
                eop_q  <= sel_eop;
                mod_q  <= sel_mod;
                data_q <= sel_data;
            end
        end
    end

    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = sop_q;
    assign pkt_tx_eop  = eop_q;
    assign pkt_tx_mod  = mod_q;
    assign pkt_tx_data = data_q;
    assign gnt_id      = gnt_q;
    assign busy        = (state_q == ARB_XFER);
    assign proto_err   = err_q;
    assign pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_xge_tx_pkt_arbiter.sv
// Self-checking bench: per-requester packet queues, a packet-level arbitration model, per-cycle checks.
module tb_xge_tx_pkt_arbiter;

    localparam int N  = 4;
    localparam int GW = 2;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
        int          src;
    } word_t;

    logic            clk_156m25;
    logic            reset_156m25_n;
    logic [N-1:0]    req_val, req_sop, req_eop, req_rdy;
    logic [3*N-1:0]  req_mod;
    logic [64*N-1:0] req_data;
    logic            pkt_tx_full;
    logic            pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]      pkt_tx_mod;
    logic [63:0]     pkt_tx_data;
    logic [GW-1:0]   gnt_id;
    logic            busy, proto_err;
    logic [31:0]     pkt_cnt;

    xge_tx_pkt_arbiter #(.N_REQ(N)) dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .req_val        (req_val),
        .req_sop        (req_sop),
        .req_eop        (req_eop),
        .req_mod        (req_mod),
        .req_data       (req_data),
        .req_rdy        (req_rdy),
        .pkt_tx_full    (pkt_tx_full),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_data    (pkt_tx_data),
        .gnt_id         (gnt_id),
        .busy           (busy),
        .proto_err      (proto_err),
        .pkt_cnt        (pkt_cnt)
    );

    initial clk_156m25 = 1'b0;
    always #5 clk_156m25 = ~clk_156m25;

    int          checks, errors;
    word_t       rq[N][$];
    word_t       exp_q[$];
    int          order_q[$];
    int          exp_ptr;
    logic [31:0] exp_cnt;
    bit          exp_err, exp_first;
    bit          prev_acc, prev_full, prev_out_eop, saw_val;
    int          full_hold;
    bit          gap_en, rand_full, junk_en;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        req_val = '0; req_sop = '0; req_eop = '0; req_mod = '0; req_data = '0;
        pkt_tx_full = 1'b0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        order_q.delete();
        exp_ptr = N - 1;
        exp_cnt = '0;
        exp_err = 1'b0;
        exp_first = 1'b1;
        prev_acc = 1'b0; prev_full = 1'b0; prev_out_eop = 1'b0; saw_val = 1'b0;
        full_hold = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_val"},  pkt_tx_val, 0);
        check({tag, "_sop"},  pkt_tx_sop, 0);
        check({tag, "_eop"},  pkt_tx_eop, 0);
        check({tag, "_mod"},  pkt_tx_mod, 0);
        check({tag, "_data"}, pkt_tx_data, 0);
        check({tag, "_gnt"},  gnt_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_perr"}, proto_err, 0);
        check({tag, "_cnt"},  pkt_cnt, 0);
        check({tag, "_rdy"},  req_rdy, 0);
    endtask

    task automatic add_pkt(input int r, input int len, input int err_at,
                           input logic [63:0] base, input logic [2:0] mod);
        word_t x;
        for (int k = 0; k < len; k++) begin
            x.sop  = (k == 0) || (k == err_at);
            x.eop  = (k == len - 1);
            x.mod  = x.eop ? mod : 3'($urandom_range(7));
            x.data = base + 64'(k);
            x.src  = r;
            rq[r].push_back(x);
        end
    endtask

    // Packet-level arbitration: whole packets, next non-empty requester after the last winner.
    task automatic build_expected();
        word_t mq[N][$];
        word_t x;
        int    w;
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        for (int guard = 0; guard < 1000; guard++) begin
            w = -1;
`ifdef XGE_TX_ARB_PRIO_EN
            if (mq[0].size() > 0) w = 0;
`endif
            for (int k = 1; k <= N; k++)
                if (w < 0 && mq[(exp_ptr + k) % N].size() > 0) w = (exp_ptr + k) % N;
            if (w < 0) break;
            do begin
                x = mq[w].pop_front();
                exp_q.push_back(x);
            end while (!x.eop && mq[w].size() > 0);
            exp_ptr = w;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_val[i] = rq[i][0].sop ? 1'b1 : (gap_en ? ($urandom_range(3) != 0) : 1'b1);
                req_sop[i] = rq[i][0].sop;
                req_eop[i] = rq[i][0].eop;
                req_mod[3*i +: 3]   = rq[i][0].mod;
                req_data[64*i +: 64] = rq[i][0].data;
            end else begin
                req_val[i] = junk_en ? 1'($urandom_range(1)) : 1'b0;
                req_sop[i] = 1'b0;
                req_eop[i] = 1'($urandom_range(1));
                req_mod[3*i +: 3]   = 3'($urandom_range(7));
                req_data[64*i +: 64] = {$urandom, $urandom};
            end
        end
        if (full_hold > 0) begin
            pkt_tx_full = 1'b1;
            full_hold--;
        end else begin
            pkt_tx_full = rand_full ? ($urandom_range(3) == 0) : 1'b0;
        end
    endtask

    task automatic check_outputs();
        word_t e;
        check("val_latency", pkt_tx_val, prev_acc);
        if (prev_full) check("val_while_full", pkt_tx_val, 0);
        if (prev_out_eop) check("pkt_gap", pkt_tx_val, 0);
        prev_out_eop = 1'b0;
        if (pkt_tx_val === 1'b1) begin
            saw_val = 1'b1;
            if (pkt_tx_sop === 1'b1) order_q.push_back(int'(gnt_id));
            check("exp_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data", pkt_tx_data, e.data);
                check("sop", pkt_tx_sop, e.sop);
                check("eop", pkt_tx_eop, e.eop);
                check("gnt_id", gnt_id, e.src);
                if (e.sop && !exp_first) exp_err = 1'b1;
                exp_first = e.eop;
                if (e.eop) begin
                    check("mod", pkt_tx_mod, e.mod);
                    exp_cnt = exp_cnt + 32'd1;
                    check("pkt_cnt", pkt_cnt, exp_cnt);
                end
                prev_out_eop = e.eop;
            end
        end
        check("proto_err", proto_err, exp_err);
    endtask

    task automatic cycle();
        bit acc;
        @(negedge clk_156m25);
        check_outputs();
        drive();
        #1;
        acc = 1'b0;
        check("rdy_onehot", $countones(req_rdy) <= 1, 1);
        if (pkt_tx_full === 1'b1) check("rdy_full", req_rdy, 0);
        if (busy !== 1'b1) check("rdy_idle", req_rdy, 0);
        else if (exp_q.size() > 0) check("rdy_other", req_rdy & ~(4'(1) << exp_q[0].src), 0);
        for (int i = 0; i < N; i++) begin
            if (req_val[i] === 1'b1 && req_rdy[i] === 1'b1 && rq[i].size() > 0) begin
                acc = 1'b1;
                void'(rq[i].pop_front());
            end
        end
        prev_acc  = acc;
        prev_full = (pkt_tx_full === 1'b1);
    endtask

    task automatic do_reset(input bit x_inputs, input string tag);
        reset_156m25_n = 1'b0;
        if (x_inputs) begin
            req_val = 'x; req_sop = 'x; req_eop = 'x; req_mod = 'x; req_data = 'x;
            pkt_tx_full = 1'bx;
        end else begin
            zero_inputs();
        end
        #1;
        check_all_zero(tag);
        reset_model();
        @(negedge clk_156m25);
        zero_inputs();
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        cycle();
        cycle();
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic drain(input int budget, input string tag);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) cycle();
        check({tag, "_drained"}, exp_q.size(), 0);
        cycle();
        cycle();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_cnt_end"}, pkt_cnt, exp_cnt);
    endtask

    task automatic check_order(input string tag, input int e[4], input int n);
        check({tag, "_order_len"}, order_q.size(), n);
        for (int k = 0; k < n; k++)
            if (k < order_q.size()) check({tag, "_order"}, order_q[k], e[k]);
    endtask

    initial begin
        int e4[4];
        checks = 0; errors = 0;
        gap_en = 1'b0; rand_full = 1'b0; junk_en = 1'b0;
        reset_156m25_n = 1'b1;
        zero_inputs();
        reset_model();
        #1;

        // Reset with undriven inputs
        do_reset(1'b1, "t1_rst");

        // Single 3-word packet from requester 1
        add_pkt(1, 3, -1, 64'h1111_0000_0000_0001, 3'd5);
        build_expected();
        drain(50, "t2");
        check("t2_gnt", gnt_id, 1);
        check("t2_cnt", pkt_cnt, 1);

        // All four requesters hold a 2-word packet from the first cycle
        do_reset(1'b0, "t3_rst");
        for (int r = 0; r < N; r++) add_pkt(r, 2, -1, 64'(r) << 56, 3'(r + 1));
        build_expected();
        drain(100, "t3");
        e4 = '{0, 1, 2, 3};
        check_order("t3", e4, 4);
        check("t3_cnt", pkt_cnt, 4);

        // Backpressure for 5 cycles in the middle of a 6-word packet
        add_pkt(2, 6, -1, 64'hF00D_0000_0000_0000, 3'd3);
        build_expected();
        saw_val = 1'b0;
        for (int n = 0; n < 20 && !saw_val; n++) cycle();
        check("t4_started", saw_val, 1);
        full_hold = 5;
        drain(100, "t4");

        // Grantee raises sop on word 2 of a 4-word packet
        add_pkt(3, 4, 1, 64'hBAD0_0000_0000_0000, 3'd7);
        build_expected();
        drain(50, "t5");
        check("t5_sticky", proto_err, 1);
        for (int n = 0; n < 4; n++) cycle();
        check("t5_still", proto_err, 1);

        // Requesters 0 and 2 request back to back
        do_reset(1'b0, "t6_rst");
        add_pkt(0, 2, -1, 64'hA000_0000_0000_0000, 3'd1);
        add_pkt(0, 3, -1, 64'hA100_0000_0000_0000, 3'd2);
        add_pkt(2, 2, -1, 64'hC000_0000_0000_0000, 3'd3);
        add_pkt(2, 1, -1, 64'hC100_0000_0000_0000, 3'd4);
        build_expected();
        drain(100, "t6");
`ifdef XGE_TX_ARB_PRIO_EN
        e4 = '{0, 0, 2, 2};
`else
        e4 = '{0, 2, 0, 2};
`endif
        check_order("t6", e4, 4);

        // Random traffic with gaps, random backpressure and val-without-sop noise
        gap_en = 1'b1; rand_full = 1'b1; junk_en = 1'b1;
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++)
                    add_pkt(r, $urandom_range(1, 5), -1, {$urandom, $urandom}, 3'($urandom_range(7)));
            end
            build_expected();
            drain(1500, "t7");
        end
        gap_en = 1'b0; rand_full = 1'b0; junk_en = 1'b0;

        // Asynchronous reset in the middle of a packet, then recovery
        add_pkt(3, 5, -1, 64'h5555_0000_0000_0000, 3'd2);
        build_expected();
        saw_val = 1'b0;
        for (int n = 0; n < 20 && !saw_val; n++) cycle();
        check("t8_started", saw_val, 1);
        @(posedge clk_156m25);
        #2;
        do_reset(1'b0, "t8_rst");
        add_pkt(1, 1, -1, 64'h0000_0000_0000_0B0B, 3'd6);
        add_pkt(0, 2, -1, 64'h0000_0000_0000_0A0A, 3'd4);
        build_expected();
        drain(50, "t8");
        e4 = '{0, 1, 0, 0};
        check_order("t8", e4, 2);
        check("t8_cnt", pkt_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
